// File: rtl/mcs4_rom_arb.sv
// mcs4_rom_arb: MCS-4 ROM emulation that shares one program memory between CPU fetches and a host port.
// The phase tracker follows CPU sync, and a host request waits only when it collides with an A3 fetch.
module mcs4_rom_arb (
   input  logic        clk,
   input  logic        rst,
   input  logic        sync,
   input  logic [3:0]  cpu_dbus,
   output logic [3:0]  rom_dout,
   output logic        mem_en,
   output logic        mem_we,
   output logic [11:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        host_req,
   input  logic        host_we,
   input  logic [11:0] host_addr,
   input  logic [7:0]  host_wdata,
   output logic        host_gnt,
   output logic        host_rvalid,
   output logic [7:0]  host_rdata,
   output logic        locked,
   output logic        sync_err
);

   typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

   phase_t     phase, phase_nxt;
   logic       locked_q, sync_err_q, rvalid_q;
   logic [3:0] addr_lo, addr_mid, fetch_buf;
   logic       fetch, grant;

   always_ff @(posedge clk) begin
      if (rst) phase <= A1;
      else     phase <= phase_nxt;
   end

   always_comb begin
      phase_nxt = sync ? A1 : phase_t'(phase + 3'd1);
   end

   // Only the low nibble of the fetched byte is replayed in M2, so only it is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         locked_q   <= 1'b0;
         sync_err_q <= 1'b0;
         addr_lo    <= 4'h0;
         addr_mid   <= 4'h0;
         fetch_buf  <= 4'h0;
         rvalid_q   <= 1'b0;
      end else begin
         if (sync) locked_q <= 1'b1;
         if (sync && locked_q && phase != X3) sync_err_q <= 1'b1;
         if (locked_q && phase == A1) addr_lo <= cpu_dbus;
         if (locked_q && phase == A2) addr_mid <= cpu_dbus;
         if (locked_q && phase == M1) fetch_buf <= mem_rdata[3:0];
         rvalid_q <= grant && !host_we;
      end
   end

   // The A3 fetch always wins the memory; the host takes every other cycle.
   always_comb begin
      fetch       = !rst && locked_q && phase == A3;
      grant       = !rst && host_req && !fetch;
      mem_en      = fetch || grant;
      mem_we      = grant && host_we;
      mem_addr    = fetch ? {cpu_dbus, addr_mid, addr_lo} : grant ? host_addr : 12'h000;
      mem_wdata   = mem_we ? host_wdata : 8'h00;
      host_gnt    = grant;
      host_rvalid = !rst && rvalid_q;
      host_rdata  = host_rvalid ? mem_rdata : 8'h00;
      rom_dout    = (rst || !locked_q) ? 4'h0 :
                    phase == M1 ? mem_rdata[7:4] :
                    phase == M2 ? fetch_buf : 4'h0;
      locked      = !rst && locked_q;
      sync_err    = !rst && sync_err_q;
   end

endmodule

// File: tb/tb_mcs4_rom_arb.sv
// tb_mcs4_rom_arb: directed checks of fetch, host arbitration, sync tracking and reset.
// A one-cycle-latency program memory lives in the bench.
module tb_mcs4_rom_arb;

   logic        clk = 1'b0;
   logic        rst, sync, host_req, host_we;
   logic [3:0]  cpu_dbus, rom_dout;
   logic        mem_en, mem_we, host_gnt, host_rvalid, locked, sync_err;
   logic [11:0] mem_addr, host_addr;
   logic [7:0]  mem_wdata, host_wdata, host_rdata;
   logic [7:0]  mem_rdata = 8'h00;
   logic [7:0]  mem [4096];
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
   end

   mcs4_rom_arb dut (
      .clk(clk), .rst(rst), .sync(sync), .cpu_dbus(cpu_dbus), .rom_dout(rom_dout),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .host_req(host_req), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
      .host_rvalid(host_rvalid), .host_rdata(host_rdata), .locked(locked),
      .sync_err(sync_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic host(input logic req, input logic we, input logic [11:0] a, input logic [7:0] d);
      host_req = req; host_we = we; host_addr = a; host_wdata = d;
   endtask

   initial begin
      rst = 1'b1; sync = 1'b0; cpu_dbus = 4'h0;
      host(1'b0, 1'b0, 12'h000, 8'h00);
      cyc(); cyc(); #4;
      chk("rst_locked", locked, 0);
      chk("rst_sync_err", sync_err, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_gnt", host_gnt, 0);
      chk("rst_rvalid", host_rvalid, 0);
      chk("rst_rom_dout", rom_dout, 0);
      // unlocked: write then read 0xFFF on consecutive cycles
      cyc(); rst = 1'b0; host(1'b1, 1'b1, 12'hFFF, 8'h42); #4;
      chk("ul_wr_gnt", host_gnt, 1);
      chk("ul_wr_we", mem_we, 1);
      chk("ul_wr_addr", mem_addr, 12'hFFF);
      chk("ul_wr_data", mem_wdata, 8'h42);
      cyc(); host(1'b1, 1'b0, 12'hFFF, 8'h00); #4;
      chk("ul_rd_gnt", host_gnt, 1);
      chk("ul_rd_we", mem_we, 0);
      chk("ul_rd_wdata", mem_wdata, 0);
      cyc(); host(1'b0, 1'b0, 12'h000, 8'h00); #4;
      chk("ul_rvalid", host_rvalid, 1);
      chk("ul_rdata", host_rdata, 8'h42);
      chk("ul_rom_dout", rom_dout, 0);
      chk("ul_idle_en", mem_en, 0);
      chk("ul_idle_addr", mem_addr, 0);
      cyc(); host(1'b1, 1'b1, 12'h3A5, 8'hD7); #4;
      chk("ul_wr_rvalid", host_rvalid, 0);
      cyc(); host(1'b1, 1'b1, 12'h010, 8'h5C);
      cyc(); host(1'b0, 1'b0, 12'h000, 8'h00); sync = 1'b1; #4;
      chk("pre_lock", locked, 0);
      // frame 1: fetch 0x3A5 colliding with a host read of 0x010
      cyc(); sync = 1'b0; cpu_dbus = 4'h5; #4;
      chk("lock_set", locked, 1);
      chk("a1_no_fetch", mem_en, 0);
      cyc(); cpu_dbus = 4'hA;
      cyc(); cpu_dbus = 4'h3; host(1'b1, 1'b0, 12'h010, 8'h00); #4;
      chk("a3_fetch_en", mem_en, 1);
      chk("a3_fetch_we", mem_we, 0);
      chk("a3_fetch_addr", mem_addr, 12'h3A5);
      chk("a3_host_wait", host_gnt, 0);
      cyc(); cpu_dbus = 4'h0; #4;
      chk("m1_rom_hi", rom_dout, 4'hD);
      chk("m1_host_gnt", host_gnt, 1);
      chk("m1_host_addr", mem_addr, 12'h010);
      cyc(); host(1'b0, 1'b0, 12'h000, 8'h00); #4;
      chk("m2_rom_lo", rom_dout, 4'h7);
      chk("m2_rvalid", host_rvalid, 1);
      chk("m2_rdata", host_rdata, 8'h5C);
      cyc(); #4;
      chk("x1_rom_zero", rom_dout, 0);
      cyc(); host(1'b1, 1'b1, 12'h123, 8'h9E); #4;
      chk("x2_wr_gnt", host_gnt, 1);
      cyc(); host(1'b0, 1'b0, 12'h000, 8'h00); sync = 1'b1;
      // frame 2: coherent fetch of the freshly written 0x123
      cyc(); sync = 1'b0; cpu_dbus = 4'h3;
      cyc(); cpu_dbus = 4'h2;
      cyc(); cpu_dbus = 4'h1; #4;
      chk("coh_addr", mem_addr, 12'h123);
      cyc(); #4;
      chk("coh_m1", rom_dout, 4'h9);
      cyc(); #4;
      chk("coh_m2", rom_dout, 4'hE);
      chk("x3_sync_ok", sync_err, 0);
      cyc(); sync = 1'b1;
      // early sync in X1 realigns to A1
      cyc(); sync = 1'b0; cpu_dbus = 4'h5; #4;
      chk("early_err", sync_err, 1);
      cyc(); cpu_dbus = 4'hA;
      cyc(); cpu_dbus = 4'h3; #4;
      chk("realign_en", mem_en, 1);
      chk("realign_addr", mem_addr, 12'h3A5);
      cyc(); #4;
      chk("realign_m1", rom_dout, 4'hD);
      chk("err_sticky", sync_err, 1);
      cyc(); host(1'b1, 1'b0, 12'h3A5, 8'h00); #4;
      chk("m2_rd_gnt", host_gnt, 1);
      // reset the cycle after a read grant, with a new request left pending
      cyc(); rst = 1'b1; #4;
      chk("rst_cancel_rvalid", host_rvalid, 0);
      chk("rst_hold_gnt", host_gnt, 0);
      chk("rst_locked_low", locked, 0);
      cyc(); rst = 1'b0; #4;
      chk("post_rst_gnt", host_gnt, 1);
      chk("post_rst_locked", locked, 0);
      chk("post_rst_err", sync_err, 0);
      cyc(); host(1'b0, 1'b0, 12'h000, 8'h00); #4;
      chk("post_rst_rvalid", host_rvalid, 1);
      chk("post_rst_rdata", host_rdata, 8'hD7);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
